// File: rtl/adder2_stream_ctrl.sv
// Valid/ready operand stage (S1) and result stage (S2) wrapped around an external
// combinational 8-bit adder, with an accumulate path that feeds the last result back as operand A.
module adder2_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_carry,
    output logic [7:0]       acc_q,
    output logic [CNT_W-1:0] op_count
);

    logic       s1_valid;
    logic       s2_valid;
    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic       s1_acc;
    logic       out_fire;
    logic       s2_free;
    logic       s1_adv;
    logic       in_fire;

    // S1 may refill in the same cycle it hands its op to S2.
    always_comb begin
        out_fire = s2_valid & out_ready;
        s2_free  = !s2_valid | out_fire;
        s1_adv   = s1_valid & s2_free;
        in_ready = !s1_valid | s1_adv;
        in_fire  = in_valid & in_ready;
    end

    // acc_q is only read at an op's own advance, so earlier ops have already updated it.
    assign add_a     = s1_acc ? acc_q : s1_a;
    assign add_b     = s1_b;
    assign out_valid = s2_valid;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_valid <= 1'b0;
            s1_a     <= 8'h00;
            s1_b     <= 8'h00;
            s1_acc   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_acc   <= in_acc;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s2_valid  <= 1'b0;
            out_sum   <= 8'h00;
            out_carry <= 1'b0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            out_sum   <= add_sum;
            out_carry <= (add_sum < add_a);
        end else if (out_fire) begin
            s2_valid  <= 1'b0;
        end
    end

    // A clear wins over the update from an op advancing in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            acc_q <= 8'h00;
        end else if (acc_clr) begin
            acc_q <= 8'h00;
        end else if (s1_adv) begin
            acc_q <= add_sum;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder2_stream_ctrl.sv
// Self-checking bench for adder2_stream_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based transaction model.
module tb_adder2_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;

    logic        in_ready, out_valid, out_carry;
    logic [7:0]  add_a, add_b, add_sum, out_sum, acc_q;
    logic [15:0] op_count;

    logic        in_ready4, out_valid4, out_carry4;
    logic [7:0]  add_a4, add_b4, add_sum4, out_sum4, acc_q4;
    logic [3:0]  op_count4;

    // The external adder block.
    assign add_sum  = add_a + add_b;
    assign add_sum4 = add_a4 + add_b4;

    adder2_stream_ctrl #(.CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .acc_q(acc_q), .op_count(op_count)
    );

    // Narrow-counter copy on the same stimulus, used to see op_count wrap.
    adder2_stream_ctrl #(.CNT_W(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
        .add_a(add_a4), .add_b(add_b4), .add_sum(add_sum4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4),
        .out_carry(out_carry4), .acc_q(acc_q4), .op_count(op_count4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       acc;
        logic       done;
        logic [7:0] sum;
        logic       carry;
    } op_t;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        int         cyc;
    } res_t;

    typedef struct {
        logic       clr;
        logic [7:0] a;
        logic [7:0] b;
        logic       acc;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    // Model: ordered list of accepted ops (at most one computed, one waiting) plus visible registers.
    op_t        pipe[$];
    res_t       delivered[$];
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_sum = 8'h00;
    logic       m_carry = 1'b0;
    int         m_cnt = 0;
    int         m_accepted = 0;
    int         cycle_no = 0;
    int         checks = 0;
    int         failures = 0;
    int         base;
    int         ghost;
    int         n;
    vec_t       vecs[7];
    logic [7:0] chain_b[3];

    function automatic logic has_done();
        return pipe.size() > 0 && pipe[0].done;
    endfunction

    function automatic logic has_pend();
        return pipe.size() > 0 && !pipe[pipe.size()-1].done;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    // One clock: compare every output with the model mid-cycle, then advance the model.
    task automatic applyStimulus();
        logic       hd, hp, adv_ok, exp_ready;
        logic [7:0] a_eff;
        logic [8:0] wide;
        op_t        e;
        res_t       r;
        @(negedge clk);
        hd        = has_done();
        hp        = has_pend();
        adv_ok    = !hd || out_ready;
        exp_ready = !hp || adv_ok;
        checkOutput("out_valid", out_valid, hd);
        checkOutput("in_ready", in_ready, exp_ready);
        checkOutput("out_sum", out_sum, m_sum);
        checkOutput("out_carry", out_carry, m_carry);
        checkOutput("acc_q", acc_q, m_acc);
        checkOutput("op_count", op_count, m_cnt[15:0]);
        checkOutput("op_count4", op_count4, m_cnt[3:0]);
        checkOutput("out_sum4", out_sum4, m_sum);
        if (hp) begin
            e = pipe[pipe.size()-1];
            checkOutput("add_a", add_a, e.acc ? m_acc : e.a);
            checkOutput("add_b", add_b, e.b);
        end
        if (rst) begin
            pipe.delete();
            m_acc   = 8'h00;
            m_sum   = 8'h00;
            m_carry = 1'b0;
            m_cnt   = 0;
        end else begin
            if (hd && out_ready) begin
                r.sum   = pipe[0].sum;
                r.carry = pipe[0].carry;
                r.cyc   = cycle_no;
                delivered.push_back(r);
                void'(pipe.pop_front());
                m_cnt++;
            end
            if (hp && adv_ok) begin
                e       = pipe[pipe.size()-1];
                a_eff   = e.acc ? m_acc : e.a;
                wide    = {1'b0, a_eff} + {1'b0, e.b};
                e.done  = 1'b1;
                e.sum   = wide[7:0];
                e.carry = wide[8];
                pipe[pipe.size()-1] = e;
                m_sum   = wide[7:0];
                m_carry = wide[8];
                m_acc   = wide[7:0];
            end
            if (acc_clr) m_acc = 8'h00;
            if (in_valid && exp_ready) begin
                e.a = in_a; e.b = in_b; e.acc = in_acc;
                e.done = 1'b0; e.sum = 8'h00; e.carry = 1'b0;
                pipe.push_back(e);
                m_accepted++;
            end
        end
        cycle_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int want);
        int k = 0;
        while (delivered.size() < want && k < 50) begin
            applyStimulus();
            k++;
        end
        checkOutput("drain_count", delivered.size(), want);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[1] = '{1'b0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{1'b1, 8'hAA, 8'h05, 1'b1, 8'h05, 1'b0};
        vecs[5] = '{1'b0, 8'h5A, 8'h10, 1'b1, 8'h15, 1'b0};
        vecs[6] = '{1'b0, 8'hC3, 8'hF0, 1'b1, 8'h05, 1'b1};
        chain_b[0] = 8'h05;
        chain_b[1] = 8'h10;
        chain_b[2] = 8'hF0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_sum", out_sum, 8'h00);
        checkOutput("rst_out_carry", out_carry, 1'b0);
        checkOutput("rst_acc_q", acc_q, 8'h00);
        checkOutput("rst_op_count", op_count, 16'h0);

        // Directed vectors, one op at a time.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) begin
                acc_clr = 1'b1;
                applyStimulus();
                acc_clr = 1'b0;
            end
            delivered.delete();
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_acc = vecs[i].acc;
            applyStimulus();
            in_valid = 1'b0; in_acc = 1'b0;
            n = 0;
            while (delivered.size() == 0 && n < 10) begin
                applyStimulus();
                n++;
            end
            checkOutput("vec_delivered", delivered.size(), 1);
            if (delivered.size() != 0) begin
                checkOutput("vec_sum", delivered[0].sum, vecs[i].sum);
                checkOutput("vec_carry", delivered[0].carry, vecs[i].carry);
            end
            checkOutput("vec_latency", n, 2);
            checkOutput("vec_acc_q", acc_q, vecs[i].sum);
        end
        checkOutput("vec_op_count", op_count, 16'd7);

        // Back-to-back accumulate chain.
        acc_clr = 1'b1;
        applyStimulus();
        acc_clr = 1'b0;
        delivered.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_acc = 1'b1; in_a = 8'($urandom); in_b = chain_b[i];
            applyStimulus();
        end
        in_valid = 1'b0; in_acc = 1'b0;
        drain(3);
        if (delivered.size() >= 3) begin
            checkOutput("chain_sum0", delivered[0].sum, 8'h05);
            checkOutput("chain_sum1", delivered[1].sum, 8'h15);
            checkOutput("chain_sum2", delivered[2].sum, 8'h05);
            checkOutput("chain_carry", {delivered[0].carry, delivered[1].carry, delivered[2].carry}, 3'b001);
            checkOutput("chain_gap1", delivered[1].cyc - delivered[0].cyc, 1);
            checkOutput("chain_gap2", delivered[2].cyc - delivered[1].cyc, 1);
        end

        // Backpressure: three ops offered while downstream stalls.
        out_ready = 1'b0;
        delivered.delete();
        base = m_accepted;
        for (int c = 0; c < 6; c++) begin
            in_valid = (m_accepted - base) < 3;
            in_a = 8'(m_accepted - base + 1); in_b = 8'h10;
            applyStimulus();
        end
        in_valid = 1'b1;
        in_a = 8'(m_accepted - base + 1);
        checkOutput("bp_in_ready", in_ready, 1'b0);
        checkOutput("bp_out_valid", out_valid, 1'b1);
        checkOutput("bp_out_sum", out_sum, 8'h11);
        out_ready = 1'b1;
        applyStimulus();
        in_valid = 1'b0;
        drain(3);
        if (delivered.size() >= 3) begin
            checkOutput("bp_sum0", delivered[0].sum, 8'h11);
            checkOutput("bp_sum1", delivered[1].sum, 8'h12);
            checkOutput("bp_sum2", delivered[2].sum, 8'h13);
            checkOutput("bp_span", delivered[2].cyc - delivered[0].cyc, 2);
        end

        // Clear in the same cycle the op advances.
        delivered.delete();
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_acc = 1'b0;
        applyStimulus();
        in_valid = 1'b0;
        acc_clr = 1'b1;
        applyStimulus();
        acc_clr = 1'b0;
        checkOutput("clr_acc_q", acc_q, 8'h00);
        checkOutput("clr_out_sum", out_sum, 8'h33);
        checkOutput("clr_out_valid", out_valid, 1'b1);
        drain(1);

        // Reset with two ops in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h21; in_b = 8'h02;
        applyStimulus();
        in_a = 8'h31; in_b = 8'h03;
        applyStimulus();
        in_valid = 1'b0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("mrst_out_valid", out_valid, 1'b0);
        checkOutput("mrst_in_ready", in_ready, 1'b1);
        checkOutput("mrst_acc_q", acc_q, 8'h00);
        checkOutput("mrst_op_count", op_count, 16'h0);
        out_ready = 1'b1;
        ghost = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            if (out_valid) ghost++;
        end
        checkOutput("mrst_no_ghost", ghost, 0);

        // Seventeen handshakes from reset: the 4-bit counter wraps to 1.
        delivered.delete();
        for (int c = 0; c < 17; c++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'($urandom);
            applyStimulus();
        end
        in_valid = 1'b0; in_acc = 1'b0;
        drain(17);
        checkOutput("wrap_op_count4", op_count4, 4'd1);
        checkOutput("wrap_op_count", op_count, 16'd17);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_acc    = 1'($urandom);
            acc_clr   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
